branch_resolve_unit: RTL and testbench

//  Parametrised, registered branch resolution stage for the RISC-V core. Evaluates the

---
 rtl/branch_resolve_unit.sv | 87 ++++++++
 tb/tb_branch_resolve_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch compare, redirect target, mispredict detect and bimodal BHT training
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic             in_pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic             accept, taken, illegal, mispredict, eq, lt, ltu;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  target;
    logic             unused_bits;

    assign pred_taken  = bht[pred_pc[IDX_W+1:2]][1];
    assign in_ready    = !out_valid | out_ready;
    assign accept      = in_valid & in_ready & !flush;
    assign idx         = pc[IDX_W+1:2];
    assign unused_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    // funct3[2:1] selects eq/lt/ltu, funct3[0] inverts; 010/011 are illegal and never taken
    always_comb begin
        eq         = rs1_data == rs2_data;
        lt         = $signed(rs1_data) < $signed(rs2_data);
        ltu        = rs1_data < rs2_data;
        illegal    = funct3[2:1] == 2'b01;
        taken      = !illegal & ((funct3[2] ? (funct3[1] ? ltu : lt) : eq) ^ funct3[0]);
        mispredict = taken != in_pred_taken;
        target     = taken ? pc + imm : pc + XLEN'(4);
    end

    // result register with valid/ready hold; flush discards both held and incoming results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_target     <= '0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
        end else begin
            out_valid <= !flush && (accept || (out_valid && !out_ready));
            if (accept) begin
                out_taken      <= taken;
                out_target     <= target;
                out_mispredict <= mispredict;
                out_illegal    <= illegal;
            end
        end
    end

    // 2-bit saturating bimodal training on legal accepted branches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (accept && !illegal) begin
            bht[idx] <= taken ? (bht[idx] == 2'b11 ? 2'b11 : bht[idx] + 2'd1)
                              : (bht[idx] == 2'b00 ? 2'b00 : bht[idx] - 2'd1);
        end
    end

    // saturating count of accepted mispredicts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mispredict_cnt <= '0;
        else if (accept && mispredict && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table vectors, corner sequences and random traffic against a reference model
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pred_pc = '0;
    logic        pred_taken;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] pc = '0, rs1_data = '0, rs2_data = '0, imm = '0;
    logic        in_pred_taken = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_taken;
    logic [31:0] out_target;
    logic        out_mispredict;
    logic        out_illegal;
    logic [15:0] mispredict_cnt;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .in_pred_taken(in_pred_taken),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_target(out_target), .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] pc, a, b, imm;
        logic        pred, taken;
        logic [31:0] target;
        logic        mis, ill;
    } vec_t;

    vec_t        tbl[9];
    int          vectors = 0, miscompares = 0;
    int          m_bht[16];
    bit          m_valid, m_taken, m_mis, m_ill;
    logic [31:0] m_target;
    int          m_cnt;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_outcome(logic [2:0] f3, logic [31:0] a, logic [31:0] b, output bit t, output bit ill);
        ill = 0;
        case (f3)
            3'd0: t = a == b;
            3'd1: t = a != b;
            3'd4: t = $signed(a) < $signed(b);
            3'd5: t = $signed(a) >= $signed(b);
            3'd6: t = a < b;
            3'd7: t = a >= b;
            default: begin t = 0; ill = 1; end
        endcase
    endfunction

    function automatic void model_reset();
        foreach (m_bht[i]) m_bht[i] = 1;
        m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0; m_target = '0; m_cnt = 0;
    endfunction

    task automatic drive(logic [2:0] f3, logic [31:0] p, logic [31:0] a, logic [31:0] b, logic [31:0] im, logic pr);
        funct3 = f3; pc = p; rs1_data = a; rs2_data = b; imm = im; in_pred_taken = pr;
    endtask

    task automatic step();
        bit rdy, acc, t, ill;
        #1;
        rdy = !m_valid || out_ready;
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("pred_taken", 32'(pred_taken), 32'(m_bht[pred_pc[5:2]] >= 2));
        acc = in_valid && rdy && !flush;
        ref_outcome(funct3, rs1_data, rs2_data, t, ill);
        if (acc) begin
            m_taken = t; m_ill = ill; m_mis = t != in_pred_taken;
            m_target = t ? pc + imm : pc + 32'd4;
            if (!ill) m_bht[pc[5:2]] = t ? (m_bht[pc[5:2]] < 3 ? m_bht[pc[5:2]] + 1 : 3)
                                         : (m_bht[pc[5:2]] > 0 ? m_bht[pc[5:2]] - 1 : 0);
            if (m_mis && m_cnt < 65535) m_cnt++;
        end
        m_valid = !flush && (acc || (m_valid && !out_ready));
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("mispredict_cnt", 32'(mispredict_cnt), 32'(m_cnt));
        if (m_valid) begin
            check("out_taken", 32'(out_taken), 32'(m_taken));
            check("out_target", out_target, m_target);
            check("out_mispredict", 32'(out_mispredict), 32'(m_mis));
            check("out_illegal", 32'(out_illegal), 32'(m_ill));
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_taken", 32'(out_taken), 32'd0);
        check("rst_out_target", out_target, 32'd0);
        check("rst_out_mispredict", 32'(out_mispredict), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);
        check("rst_cnt", 32'(mispredict_cnt), 32'd0);
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] held, cnt0;
        tbl[0] = '{3'b000, 32'h100, 32'h5, 32'h5, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1, 1'b0};
        tbl[1] = '{3'b100, 32'h200, 32'hFFFFFFFF, 32'h1, 32'h10, 1'b0, 1'b1, 32'h210, 1'b1, 1'b0};
        tbl[2] = '{3'b110, 32'h200, 32'hFFFFFFFF, 32'h1, 32'h10, 1'b1, 1'b0, 32'h204, 1'b1, 1'b0};
        tbl[3] = '{3'b101, 32'h300, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1, 1'b1, 32'h2F0, 1'b0, 1'b0};
        tbl[4] = '{3'b111, 32'h300, 32'h1, 32'hFFFFFFFF, 32'h40, 1'b0, 1'b0, 32'h304, 1'b0, 1'b0};
        tbl[5] = '{3'b001, 32'h10, 32'h3, 32'h3, 32'h8, 1'b1, 1'b0, 32'h14, 1'b1, 1'b0};
        tbl[6] = '{3'b000, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h8, 1'b1, 1'b1, 32'h4, 1'b0, 1'b0};
        tbl[7] = '{3'b010, 32'h40, 32'h7, 32'h7, 32'h100, 1'b1, 1'b0, 32'h44, 1'b1, 1'b1};
        tbl[8] = '{3'b011, 32'h80, 32'h7, 32'h9, 32'h100, 1'b0, 1'b0, 32'h84, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        pulse_reset();

        // table vectors, one accept per cycle, always drained
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].f3, tbl[i].pc, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].pred);
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            check($sformatf("tbl%0d_taken", i), 32'(out_taken), 32'(tbl[i].taken));
            check($sformatf("tbl%0d_target", i), out_target, tbl[i].target);
            check($sformatf("tbl%0d_mis", i), 32'(out_mispredict), 32'(tbl[i].mis));
            check($sformatf("tbl%0d_ill", i), 32'(out_illegal), 32'(tbl[i].ill));
            if (i == 0) check("first_cnt", 32'(mispredict_cnt), 32'd1);
        end
        in_valid = 1'b0;
        step();

        // BHT training at pc 0x40; illegal leaves entry at 01
        pulse_reset();
        pred_pc = 32'h40;
        drive(3'b010, 32'h40, 0, 0, 0, 1'b0);
        in_valid = 1'b1;
        step();
        #1;
        check("bht_illegal_untouched", 32'(pred_taken), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, 32'h40, 32'h1, 32'h2, 32'h10, 1'b0);
            step();
            #1;
            check($sformatf("bht_train%0d", i), 32'(pred_taken), 32'd1);
        end
        drive(3'b000, 32'h40, 32'h1, 32'h2, 32'h10, 1'b1);
        step();
        #1;
        check("bht_11_to_10", 32'(pred_taken), 32'd1);

        // backpressure: three held cycles, then second request accepted
        drive(3'b000, 32'h500, 32'h1, 32'h1, 32'h30, 1'b1);
        step();
        held = out_target;
        check("hold_first_target", held, 32'h530);
        drive(3'b001, 32'h600, 32'h1, 32'h1, 32'h30, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_target", out_target, held);
        end
        out_ready = 1'b1;
        step();
        check("release_target", out_target, 32'h604);
        in_valid = 1'b0;
        step();

        // flush with a held result and a mispredicting request
        drive(3'b000, 32'h700, 32'h2, 32'h2, 32'h8, 1'b0);
        in_valid = 1'b1;
        step();
        cnt0 = 32'(mispredict_cnt);
        out_ready = 1'b0; flush = 1'b1;
        step();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_cnt", 32'(mispredict_cnt), cnt0);
        flush = 1'b0;
        step();
        out_ready = 1'b1; flush = 1'b1;
        step();
        check("flush_ready_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;

        // async reset while a result is held
        out_ready = 1'b0;
        drive(3'b000, 32'h40, 32'h3, 32'h3, 32'h8, 1'b0);
        step();
        step();
        pred_pc = 32'h40;
        pulse_reset();
        in_valid = 1'b0; out_ready = 1'b1;
        step();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(3'($urandom), {$urandom_range(0, 3) == 0 ? 32'hFFFFFF00 : 32'h0} | ($urandom & 32'hFC),
                  $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom,
                  $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom,
                  $urandom, 1'($urandom));
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
            pred_pc   = $urandom & 32'hFC;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
